// File: rtl/distance_controller.sv
// Sequencer for the distance = velocity x steps repeated-addition datapath.
// Latency: start to done is steps+2 cycles (INIT, steps x ACCUM, DONE); outputs decode from the state register only.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while a run is in progress.
module distance_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] steps_i,
  input  logic             acc_ovf_i,
  output logic             vel_load_o,
  output logic             acc_clr_o,
  output logic             acc_load_o,
  output logic             step_inc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [WIDTH-1:0] step_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] step_count_q, step_count_d;
  logic             overflow_q, overflow_d;
  logic             last_step;

  // The addition happening this cycle is the final one of the run.
  assign last_step = (step_count_q == (target_q - ONE));

  // State, target, counter and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      step_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      step_count_q <= step_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state logic; counter and overflow hold outside INIT/ACCUM so the
  // last run's result stays visible through DONE and IDLE.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    step_count_d = step_count_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          target_d = steps_i;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        step_count_d = '0;
        overflow_d   = 1'b0;
        state_d      = (target_q == '0) ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        // The carrying addition is still performed, so it is counted.
        step_count_d = step_count_q + ONE;
        if (acc_ovf_i) begin
          overflow_d = 1'b1;
          state_d    = S_DONE;
        end else if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Back-to-back runs skip IDLE entirely.
        if (start_i) begin
          target_d = steps_i;
          state_d  = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode; strobes fall as soon as reset clears the state.
  always_comb begin
    vel_load_o = 1'b0;
    acc_clr_o  = 1'b0;
    acc_load_o = 1'b0;
    step_inc_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_INIT: begin
        vel_load_o = 1'b1;
        acc_clr_o  = 1'b1;
        busy_o     = 1'b1;
      end
      S_ACCUM: begin
        acc_load_o = 1'b1;
        step_inc_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  assign overflow_o   = overflow_q;
  assign step_count_o = step_count_q;

endmodule
